// File: rtl/din_gather_pkg.sv
// rtl/din_gather_pkg.sv - shared lane geometry, lane index and FSM state types for din_gather
package din_gather_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int NUM_LANES      = 8;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/din_gather_cnt.sv
// rtl/din_gather_cnt.sv - wrapping record-emitted and partial-record-dropped counters
module din_gather_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_inc,
    input  logic             drop_inc,
    output logic [CNT_W-1:0] rec_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (rec_inc) begin
                rec_cnt <= rec_cnt + 1'b1;
            end
            if (drop_inc) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/din_gather.sv
// rtl/din_gather.sv - byte-to-8-lane record deserializer feeding the dot-product din port (DIN_GATHER_CNT_EN adds counters)
module din_gather
    import din_gather_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
`ifdef DIN_GATHER_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_busy,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_busy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DATA_W-1:0] out_data_c,
    output logic [DATA_W-1:0] out_data_d,
    output logic [DATA_W-1:0] out_data_e,
    output logic [DATA_W-1:0] out_data_f,
    output logic [DATA_W-1:0] out_data_g,
    output logic [DATA_W-1:0] out_data_h
`ifdef DIN_GATHER_CNT_EN
    ,
    output logic [CNT_W-1:0]  rec_cnt,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

    logic [DATA_W-1:0] asm_lane [NUM_LANES];
    logic [DATA_W-1:0] out_lane [NUM_LANES];
    state_t            state;
    lane_idx_t         idx;

    logic out_free;
    logic accept;
    logic drop;
    logic emit;

    // in_busy is high exactly while FULL, so accept already implies COLLECT
    assign out_free = !out_vld || !out_busy;
    assign accept   = in_vld && !in_busy;
    assign drop     = accept && in_sop && (idx != '0);
    assign emit     = out_vld && !out_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT;
            idx     <= '0;
            in_busy <= 1'b0;
            out_vld <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                asm_lane[i] <= '0;
                out_lane[i] <= '0;
            end
        end else begin
            if (emit) begin
                out_vld <= 1'b0;
            end
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (drop) begin
                            asm_lane[0] <= in_data;
                            idx         <= lane_idx_t'(1);
                        end else begin
                            asm_lane[idx] <= in_data;
                            idx           <= idx + lane_idx_t'(1);
                            if (idx == LAST_LANE) begin
                                if (out_free) begin
                                    // final byte bypasses the assembly register
                                    for (int i = 0; i < NUM_LANES; i++) begin
                                        out_lane[i] <= (lane_idx_t'(i) == idx) ? in_data : asm_lane[i];
                                    end
                                    out_vld <= 1'b1;
                                end else begin
                                    state   <= FULL;
                                    in_busy <= 1'b1;
                                end
                            end
                        end
                    end
                end
                FULL: begin
                    if (out_free) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            out_lane[i] <= asm_lane[i];
                        end
                        out_vld <= 1'b1;
                        state   <= COLLECT;
                        in_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign out_data_a = out_lane[0];
    assign out_data_b = out_lane[1];
    assign out_data_c = out_lane[2];
    assign out_data_d = out_lane[3];
    assign out_data_e = out_lane[4];
    assign out_data_f = out_lane[5];
    assign out_data_g = out_lane[6];
    assign out_data_h = out_lane[7];

`ifdef DIN_GATHER_CNT_EN
    din_gather_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .rec_inc  (emit),
        .drop_inc (drop),
        .rec_cnt  (rec_cnt),
        .drop_cnt (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_din_gather.sv
// tb/tb_din_gather.sv - randomized self-checking bench for din_gather with a queue-based record model
module tb_din_gather;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_busy;
    logic       in_sop;
    logic [7:0] in_data;
    logic       out_busy;
    logic       out_vld;
    logic [7:0] out_data_a, out_data_b, out_data_c, out_data_d;
    logic [7:0] out_data_e, out_data_f, out_data_g, out_data_h;
`ifdef DIN_GATHER_CNT_EN
    logic [15:0] rec_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    din_gather dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_busy    (in_busy),
        .in_sop     (in_sop),
        .in_data    (in_data),
        .out_busy   (out_busy),
        .out_vld    (out_vld),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .out_data_e (out_data_e),
        .out_data_f (out_data_f),
        .out_data_g (out_data_g),
        .out_data_h (out_data_h)
`ifdef DIN_GATHER_CNT_EN
        ,
        .rec_cnt    (rec_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    // Reference model: bytes in arrival order, a record every 8, sop restarts a partial record
    logic [7:0]  partial [$];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    int          model_drops = 0;
    int          model_recs  = 0;
    int          stall_errs  = 0;
    int          busy_seen   = 0;
    logic        prev_stall  = 1'b0;
    logic [63:0] prev_rec    = '0;

    function automatic logic [63:0] cur_rec();
        return {out_data_a, out_data_b, out_data_c, out_data_d,
                out_data_e, out_data_f, out_data_g, out_data_h};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            partial.delete();
            exp_q.delete();
            got_q.delete();
            model_drops = 0;
            model_recs  = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall && (!out_vld || cur_rec() !== prev_rec)) stall_errs++;
            prev_stall = out_vld && out_busy;
            prev_rec   = cur_rec();
            if (in_busy) busy_seen++;
            if (in_vld && !in_busy) begin
                if (in_sop && partial.size() != 0) begin
                    model_drops++;
                    partial.delete();
                end
                partial.push_back(in_data);
                if (partial.size() == 8) begin
                    exp_q.push_back({partial[0], partial[1], partial[2], partial[3],
                                     partial[4], partial[5], partial[6], partial[7]});
                    partial.delete();
                end
            end
            if (out_vld && !out_busy) begin
                got_q.push_back(cur_rec());
                model_recs++;
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b0;
        in_vld   = 1'b0;
        in_sop   = 1'b0;
        in_data  = '0;
        out_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sop);
        int n = 0;
        in_vld  = 1'b1;
        in_data = b;
        in_sop  = sop;
        @(negedge clk);
        while (in_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_busy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_busy=%b required 0", in_busy);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sop = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_busy = 1'b0;
        in_vld   = 1'b0;
        while ((out_vld || in_busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (out_vld !== 1'b0 || in_busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout out_vld=%b in_busy=%b required 0 0", out_vld, in_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++;
        if (in_busy !== 1'b0) begin failures++; $display("FAIL reset_in_busy got=%b exp=0", in_busy); end
        checks++;
        if (cur_rec() !== 64'h0) begin failures++; $display("FAIL reset_lanes got=%h exp=0", cur_rec()); end
`ifdef DIN_GATHER_CNT_EN
        checks++;
        if (rec_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", rec_cnt, drop_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 7) begin
                checks++;
                if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_early_vld got=%b exp=0", out_vld); end
            end
        end
        checks++;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL basic_latency out_vld=%b exp=1", out_vld); end
        checks++;
        if (cur_rec() !== 64'h0102030405060708) begin
            failures++; $display("FAIL basic_record got=%h exp=0102030405060708", cur_rec());
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_single out_vld=%b exp=0", out_vld); end
`ifdef DIN_GATHER_CNT_EN
        checks++;
        if (rec_cnt !== 16'd1) begin failures++; $display("FAIL basic_rec_cnt got=%0d exp=1", rec_cnt); end
`endif
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL basic_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int b0;
        logic [63:0] want;
        do_reset();
        b0 = busy_seen;
        for (int i = 0; i < 24; i++) send_byte(8'(i), 1'b0);
        drain();
        checks++;
        if (busy_seen != b0) begin failures++; $display("FAIL b2b_in_busy cycles=%0d exp=0", busy_seen - b0); end
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size());
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 8; k++) want[63 - 8*k -: 8] = 8'(8*r + k);
                checks++;
                if (got_q[r] !== want || got_q[r] !== exp_q[r]) begin
                    failures++; $display("FAIL b2b_record%0d got=%h exp=%h", r, got_q[r], want);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0]  bytes [16];
        logic [63:0] rec0, rec1;
        do_reset();
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            rec0[63 - 8*k -: 8] = bytes[k];
            rec1[63 - 8*k -: 8] = bytes[8 + k];
        end
        out_busy = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(bytes[i], 1'b0);
        checks++;
        if (in_busy !== 1'b1) begin failures++; $display("FAIL stall_in_busy got=%b exp=1", in_busy); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (in_busy !== 1'b1 || out_vld !== 1'b1 || cur_rec() !== rec0) begin
            failures++; $display("FAIL stall_hold busy=%b vld=%b rec=%h exp 1 1 %h", in_busy, out_vld, cur_rec(), rec0);
        end
        out_busy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_vld !== 1'b1 || cur_rec() !== rec1 || in_busy !== 1'b0) begin
            failures++; $display("FAIL stall_release vld=%b rec=%h busy=%b exp 1 %h 0", out_vld, cur_rec(), in_busy, rec1);
        end
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== rec0 || got_q[1] !== rec1 || exp_q.size() != 2) begin
            failures++; $display("FAIL stall_order got_n=%0d exp_n=2", got_q.size());
        end
        checks++;
        if (stall_errs != 0) begin failures++; $display("FAIL stall_stability errors=%0d exp=0", stall_errs); end
    endtask

    task automatic test_sop();
        logic [63:0] want;
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        want[63:56] = 8'hAA;
        send_byte(8'hAA, 1'b1);
        for (int k = 1; k < 8; k++) begin
            want[63 - 8*k -: 8] = 8'($urandom);
            send_byte(want[63 - 8*k -: 8], 1'b0);
        end
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== want || exp_q.size() != 1) begin
            failures++; $display("FAIL sop_record got_n=%0d got=%h exp=%h", got_q.size(), got_q.size() ? got_q[0] : 64'h0, want);
        end
`ifdef DIN_GATHER_CNT_EN
        checks++;
        if (drop_cnt !== 16'd1 || rec_cnt !== 16'd1) begin
            failures++; $display("FAIL sop_counters got=%0d/%0d exp=1/1", drop_cnt, rec_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] want;
        do_reset();
        out_busy = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b0 || in_busy !== 1'b0 || cur_rec() !== 64'h0) begin
            failures++; $display("FAIL rstmid_clear vld=%b busy=%b rec=%h exp 0 0 0", out_vld, in_busy, cur_rec());
        end
`ifdef DIN_GATHER_CNT_EN
        checks++;
        if (rec_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            failures++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", rec_cnt, drop_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst      = 1'b1;
        out_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            want[63 - 8*k -: 8] = 8'($urandom);
            send_byte(want[63 - 8*k -: 8], 1'b0);
        end
        checks++;
        if (out_vld !== 1'b1 || cur_rec() !== want) begin
            failures++; $display("FAIL rstmid_record vld=%b got=%h exp=%h", out_vld, cur_rec(), want);
        end
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            failures++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
        end
    endtask

    task automatic test_random();
        int nrec;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            in_vld   = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_sop   = ($urandom_range(0, 15) == 0);
            out_busy = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
        end
        in_sop = 1'b0;
        drain();
        nrec = got_q.size();
        checks++;
        if (nrec != exp_q.size() || nrec < 50) begin
            failures++; $display("FAIL random_count got=%0d exp=%0d", nrec, exp_q.size());
        end
        for (int r = 0; r < nrec && r < exp_q.size(); r++) begin
            if (got_q[r] !== exp_q[r]) begin
                checks++;
                failures++;
                $display("FAIL random_record%0d got=%h exp=%h", r, got_q[r], exp_q[r]);
            end
        end
        checks++;
        if (stall_errs != 0) begin failures++; $display("FAIL random_stability errors=%0d exp=0", stall_errs); end
`ifdef DIN_GATHER_CNT_EN
        checks++;
        if (rec_cnt !== 16'(model_recs) || drop_cnt !== 16'(model_drops)) begin
            failures++; $display("FAIL random_counters got=%0d/%0d exp=%0d/%0d", rec_cnt, drop_cnt, model_recs, model_drops);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_sop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
